// File: rtl/keypad_number_entry.sv
// Debounced keypad front end that assembles up to four BCD digits into a number,
// with backspace, clear and enter (captures the number into result and pulses done).
module keypad_number_entry #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [13:0] value,
    output logic [2:0]  count,
    output logic [13:0] result,
    output logic        done
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] CODE_ENTER = 4'hA;
    localparam logic [3:0] CODE_BKSP  = 4'hB;
    localparam logic [3:0] CODE_CLEAR = 4'hC;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        ACCEPT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic [13:0]      value_q, value_d;
    logic [2:0]       count_q, count_d;
    logic [13:0]      result_q, result_d;
    logic             done_q, done_d;

    // value is rebuilt from the next-state digits with constant multiplies only,
    // so backspace never needs a divide-by-ten.
    function automatic logic [13:0] bcd_to_bin(input logic [3:0] b3, input logic [3:0] b2,
                                               input logic [3:0] b1, input logic [3:0] b0);
        return 14'(b3) * 14'd1000 + 14'(b2) * 14'd100 + 14'(b1) * 14'd10 + 14'(b0);
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        d3_d     = d3_q;
        d2_d     = d2_q;
        d1_d     = d1_q;
        d0_d     = d0_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    code_d  = key_code;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_valid || key_code != code_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ACCEPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACCEPT: begin
                cnt_d   = '0;
                state_d = WAIT_RELEASE;
                if (code_q <= 4'd9) begin
                    if (count_q < 3'd4) begin
                        d3_d    = d2_q;
                        d2_d    = d1_q;
                        d1_d    = d0_q;
                        d0_d    = code_q;
                        count_d = count_q + 3'd1;
                    end
                end else if (code_q == CODE_BKSP) begin
                    if (count_q != 3'd0) begin
                        d0_d    = d1_q;
                        d1_d    = d2_q;
                        d2_d    = d3_q;
                        d3_d    = 4'd0;
                        count_d = count_q - 3'd1;
                    end
                end else if (code_q == CODE_CLEAR || code_q == CODE_ENTER) begin
                    if (code_q == CODE_ENTER) begin
                        result_d = value_q;
                        done_d   = 1'b1;
                    end
                    d3_d    = 4'd0;
                    d2_d    = 4'd0;
                    d1_d    = 4'd0;
                    d0_d    = 4'd0;
                    count_d = 3'd0;
                end
            end
            WAIT_RELEASE: begin
                if (key_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        value_d = bcd_to_bin(d3_d, d2_d, d1_d, d0_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= 4'd0;
            d3_q     <= 4'd0;
            d2_q     <= 4'd0;
            d1_q     <= 4'd0;
            d0_q     <= 4'd0;
            value_q  <= 14'd0;
            count_q  <= 3'd0;
            result_q <= 14'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            d3_q     <= d3_d;
            d2_q     <= d2_d;
            d1_q     <= d1_d;
            d0_q     <= d0_d;
            value_q  <= value_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign digit3 = d3_q;
    assign digit2 = d2_q;
    assign digit1 = d1_q;
    assign digit0 = d0_q;
    assign value  = value_q;
    assign count  = count_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry with DEBOUNCE_CYCLES=4: a table of full
// key presses with expected outputs, plus hand sequences for latency, done, bounce and reset.
module tb_keypad_number_entry;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic [13:0] value;
    logic [2:0]  count;
    logic [13:0] result;
    logic        done;

    int n_cmp = 0;
    int n_fail = 0;

    keypad_number_entry #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .value(value), .count(count), .result(result), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [13:0] val;
        logic [2:0]  cnt;
        logic [15:0] dig;
        logic [13:0] res;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Full keystroke: held well past acceptance, then released long enough to rearm.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        wait_neg(N + 4);
        key_valid = 1'b0;
        wait_neg(N + 2);
    endtask

    task automatic check_outs(input string tag, input logic [13:0] v, input logic [2:0] c,
                              input logic [15:0] d, input logic [13:0] r);
        check({tag, ".value"},  16'(value), 16'(v));
        check({tag, ".count"},  16'(count), 16'(c));
        check({tag, ".digits"}, {digit3, digit2, digit1, digit0}, d);
        check({tag, ".result"}, 16'(result), 16'(r));
    endtask

    initial begin
        int  seen_done;
        tbl[0]  = '{4'h1, 14'd1,    3'd1, 16'h0001, 14'd0};
        tbl[1]  = '{4'h2, 14'd12,   3'd2, 16'h0012, 14'd0};
        tbl[2]  = '{4'h3, 14'd123,  3'd3, 16'h0123, 14'd0};
        tbl[3]  = '{4'h4, 14'd1234, 3'd4, 16'h1234, 14'd0};
        tbl[4]  = '{4'h5, 14'd1234, 3'd4, 16'h1234, 14'd0};
        tbl[5]  = '{4'hC, 14'd0,    3'd0, 16'h0000, 14'd0};
        tbl[6]  = '{4'h7, 14'd7,    3'd1, 16'h0007, 14'd0};
        tbl[7]  = '{4'h0, 14'd70,   3'd2, 16'h0070, 14'd0};
        tbl[8]  = '{4'h9, 14'd709,  3'd3, 16'h0709, 14'd0};
        tbl[9]  = '{4'hB, 14'd70,   3'd2, 16'h0070, 14'd0};
        tbl[10] = '{4'hB, 14'd7,    3'd1, 16'h0007, 14'd0};
        tbl[11] = '{4'hB, 14'd0,    3'd0, 16'h0000, 14'd0};
        tbl[12] = '{4'hB, 14'd0,    3'd0, 16'h0000, 14'd0};
        tbl[13] = '{4'h4, 14'd4,    3'd1, 16'h0004, 14'd0};
        tbl[14] = '{4'h2, 14'd42,   3'd2, 16'h0042, 14'd0};
        tbl[15] = '{4'hA, 14'd0,    3'd0, 16'h0000, 14'd42};
        tbl[16] = '{4'hC, 14'd0,    3'd0, 16'h0000, 14'd42};
        tbl[17] = '{4'hD, 14'd0,    3'd0, 16'h0000, 14'd42};
        tbl[18] = '{4'h9, 14'd9,    3'd1, 16'h0009, 14'd42};
        tbl[19] = '{4'hF, 14'd9,    3'd1, 16'h0009, 14'd42};
        tbl[20] = '{4'h3, 14'd93,   3'd2, 16'h0093, 14'd42};
        tbl[21] = '{4'hA, 14'd0,    3'd0, 16'h0000, 14'd93};

        // Reset state
        wait_neg(3);
        check_outs("reset", 14'd0, 3'd0, 16'h0000, 14'd0);
        check("reset.done", 16'(done), 16'd0);
        rst = 1'b0;
        wait_neg(1);

        for (int i = 0; i < 22; i++) begin
            press(tbl[i].code);
            check_outs($sformatf("tbl%0d", i), tbl[i].val, tbl[i].cnt, tbl[i].dig, tbl[i].res);
        end

        // Enter: exact latency and a single-cycle done pulse
        press(4'h4);
        press(4'h2);
        key_valid = 1'b1;
        key_code  = 4'hA;
        wait_neg(N + 1);
        check("enter.pre.done", 16'(done), 16'd0);
        check("enter.pre.result", 16'(result), 16'd93);
        check("enter.pre.value", 16'(value), 16'd42);
        wait_neg(1);
        check("enter.done", 16'(done), 16'd1);
        check("enter.result", 16'(result), 16'd42);
        check("enter.value", 16'(value), 16'd0);
        check("enter.count", 16'(count), 16'd0);
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            wait_neg(1);
            if (i == 10) key_valid = 1'b0;
            if (done) seen_done++;
        end
        check("enter.single_pulse", 16'(seen_done), 16'd0);
        press(4'hC);
        check("clear.keeps_result", 16'(result), 16'd42);
        check("clear.done", 16'(done), 16'd0);

        // Bounce: valid toggling 1,1,0 never completes a debounce
        for (int i = 0; i < 15; i++) begin
            key_code  = 4'h3;
            key_valid = (i % 3) != 2;
            wait_neg(1);
        end
        key_valid = 1'b0;
        wait_neg(N + 2);
        check("bounce.value", 16'(value), 16'd0);
        check("bounce.count", 16'(count), 16'd0);

        // Code change 3->5 mid-debounce aborts; 5 is then debounced afresh from IDLE
        key_valid = 1'b1;
        key_code  = 4'h3;
        wait_neg(2);
        key_code = 4'h5;
        wait_neg(N + 2);
        check("codechg.not_yet", 16'(value), 16'd0);
        wait_neg(1);
        check("codechg.accept", 16'(value), 16'd5);
        wait_neg(20);
        key_valid = 1'b0;
        wait_neg(N + 2);
        check("codechg.once.value", 16'(value), 16'd5);
        check("codechg.once.count", 16'(count), 16'd1);

        // Long hold of 8, short release, second 8
        press(4'hC);
        key_valid = 1'b1;
        key_code  = 4'h8;
        wait_neg(100);
        key_valid = 1'b0;
        wait_neg(N);
        press(4'h8);
        check("hold88.value", 16'(value), 16'd88);
        check("hold88.count", 16'(count), 16'd2);

        // Reset during WAIT_RELEASE with 6 still held, then re-accepted as a new press
        press(4'hC);
        key_valid = 1'b1;
        key_code  = 4'h6;
        wait_neg(N + 4);
        check("rst.pre.value", 16'(value), 16'd6);
        rst = 1'b1;
        wait_neg(1);
        check_outs("rst.during", 14'd0, 3'd0, 16'h0000, 14'd0);
        check("rst.during.done", 16'(done), 16'd0);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(N + 1);
        check("rst.after.not_yet", 16'(value), 16'd0);
        wait_neg(1);
        check("rst.after.value", 16'(value), 16'd6);
        check("rst.after.count", 16'(count), 16'd1);
        key_valid = 1'b0;
        wait_neg(N + 2);

        // Reset during DEBOUNCE, key released while in reset: no action
        key_valid = 1'b1;
        key_code  = 4'h7;
        wait_neg(2);
        rst = 1'b1;
        wait_neg(1);
        key_valid = 1'b0;
        wait_neg(1);
        rst = 1'b0;
        wait_neg(N + 4);
        check("rst.deb.value", 16'(value), 16'd0);
        check("rst.deb.count", 16'(count), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
